// File: rtl/ps2_key_mmio.sv
// ps2_key_mmio: PS/2 keyboard receiver feeding a CPU-polled key register.
// Deserialises PS/2 frames, drops break sequences (F0 xx) and E0 prefixes,
// and latches the last make code into key_word = {24'b0, code}. The CPU
// clears or overwrites the register by writing to KEY_ADDR. A make code
// landing in the same cycle as a CPU write wins so no key is lost.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity;
// otherwise only a bad stop bit counts as a frame error.
// Handshake: key_valid is a one-cycle, unacknowledged strobe that is high in
// exactly the cycle key_word first shows a newly latched make code; there is
// no ready, and the CPU simply polls key_word.
module ps2_key_mmio #(
  parameter int unsigned KEY_ADDR       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_wd,
  output logic [31:0] key_word,
  output logic        key_valid,
  output logic        frame_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic        ps2d_s1_q, ps2d_s2_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        brk_q, brk_d;
  logic [31:0] key_word_q, key_word_d;
  logic        key_valid_q, key_valid_d;
  logic        frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic        par_q, par_d;
`endif

  logic fall;
  logic bit_in;
  logic frame_good;
  logic cpu_hit;

  // Falling edge of the synchronised PS/2 clock; data is sampled on it.
  assign fall    = ps2c_prev_q & ~ps2c_s2_q;
  assign bit_in  = ps2d_s2_q;
  assign cpu_hit = mem_we && (mem_addr == 32'(KEY_ADDR));

  // Frame check evaluated while in STOP with bit_in being the stop bit.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_good = bit_in & (^{shift_q, par_q});
`else
    frame_good = bit_in;
`endif
  end

  // Next-state logic: receiver FSM, timeout, break tracking, key register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    brk_d       = brk_q;
    key_word_d  = key_word_q;
    key_valid_d = 1'b0;
    frame_err_d = frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    // CPU write first so a make code latched below overrides it.
    if (cpu_hit) begin
      key_word_d = mem_wd;
    end

    if (fall) begin
      to_cnt_d = 32'd0;
    end else if (state_q != ST_IDLE) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          // A high level on a fall is not a start bit; stay idle silently.
          if (!bit_in) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = ST_PARITY;
            bit_cnt_d = 3'd0;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = bit_in;
`endif
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_good) begin
            frame_err_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            brk_d = brk_q;
          end else if (brk_q) begin
            brk_d = 1'b0;
          end else begin
            key_word_d  = {24'b0, shift_q};
            key_valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (to_cnt_q == 32'(TIMEOUT_CYCLES))) begin
      // Device went quiet mid-frame: drop the partial byte, keep brk/err.
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
      to_cnt_d  = 32'd0;
    end
  end

  // State registers, synchronisers and edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      to_cnt_q    <= 32'd0;
      brk_q       <= 1'b0;
      key_word_q  <= 32'd0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      brk_q       <= brk_d;
      key_word_q  <= key_word_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Parity bit holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign key_word  = key_word_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_key_mmio.sv
// tb_ps2_key_mmio: directed and randomised PS/2 frames against a byte-level
// model of the key register (make/break/E0 rules, sticky error, CPU writes).
module tb_ps2_key_mmio;

  localparam int unsigned TMO = 200;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk, ps2_data;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_we;
  logic [31:0] key_word;
  logic        key_valid, frame_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Model state and expected key_valid payloads.
  logic [31:0] m_key;
  logic        m_brk, m_err;
  logic [31:0] exp_q[$];

  ps2_key_mmio #(.KEY_ADDR(10), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .key_word(key_word), .key_valid(key_valid), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every key_valid cycle must match the next expected make code.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("key_on_valid", key_word, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    m_key = 32'd0; m_brk = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  // Byte-level rules for one received frame.
  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
    bit good;
    good = !bs && !(PAR_EN && bp);
    if (!good) m_err = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_brk = m_brk;
    else if (m_brk) m_brk = 1'b0;
    else begin
      m_key = {24'b0, b};
      exp_q.push_back(m_key);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // One device bit; with collide set, a CPU write of 0 to address 10 is
  // placed on the clk edge that acts on this fall (third edge after it).
  task automatic send_bit(input logic b, input bit collide);
    @(negedge clk); ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    if (collide) begin
      @(negedge clk);
      @(negedge clk);
      mem_we = 1'b1; mem_addr = 32'd10; mem_wd = 32'd0;
      @(negedge clk);
      mem_we = 1'b0; mem_addr = 32'd0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input bit collide);
    logic p;
    p = (~^b) ^ bp;
    model_frame(b, bp, bs);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(~bs, collide);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 1; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); mem_we = 1'b1; mem_addr = a; mem_wd = d;
    @(negedge clk); mem_we = 1'b0; mem_addr = 32'd0; mem_wd = 32'd0;
    if (a == 32'd10) m_key = d;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key"}, key_word, m_key);
    check({tag, "_err"}, 32'(frame_err), 32'(m_err));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    bit bp, bs;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    mem_addr = 32'd0; mem_we = 1'b0; mem_wd = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_key", key_word, 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Make code
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_state("make29");
    check("make29_value", key_word, 32'h29);

    // Break sequence after clearing the register
    cpu_write(32'd10, 32'd0);
    check("cpu_clear", key_word, 32'd0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_state("break");
    check("break_value", key_word, 32'd0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_state("after_break");
    check("after_break_value", key_word, 32'h29);

    // E0 prefix leaves the key path intact
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    check_state("e0_prefix");

    // Timeout recovery
    send_partial(5);
    repeat (TMO + 2) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_state("timeout");
    check("timeout_value", key_word, 32'h1C);

    // Collision with a CPU clear, then a write to a neighbouring address
    send_frame(8'h23, 1'b0, 1'b0, 1'b1);
    check_state("collision");
    check("collision_value", key_word, 32'h23);
    cpu_write(32'd11, 32'hDEAD_BEEF);
    check("addr11_ignored", key_word, 32'h23);

    // Reset mid-frame
    send_partial(5);
    do_reset();
    check("midrst_key", key_word, 32'd0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check_state("midrst_make");

    // Parity error: parity bit flipped so the odd-parity check fails
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_state("parity");
    check("parity_err", 32'(frame_err), 32'(PAR_EN));

    // Stop error is always fatal to the frame
    do_reset();
    send_frame(8'h44, 1'b0, 1'b1, 1'b0);
    check_state("stop_err");
    check("stop_err_flag", 32'(frame_err), 32'd1);

    // Randomised frames and CPU writes
    do_reset();
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1: b = 8'hF0;
        2: b = 8'hE0;
        default: ;
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 11) == 0);
      send_frame(b, bp, bs, 1'b0);
      check_state("rand_frame");
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'd11;
        cpu_write(a, $urandom);
        check("rand_write", key_word, m_key);
      end
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
